trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 126 ++++++++++++
 tb/tb_trap_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer: on an exception it writes mepc and mcause through the shared
// CSR write port, then redirects to mtvec; on MRET it redirects to mepc.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module trap_ctrl #(
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   exc_valid,
    input  logic                   exc_is_irq,
    input  logic [4:0]             exc_code,
    input  logic [`DATA_WIDTH-1:0] exc_pc,
    input  logic                   mret_valid,
    output logic                   req_ack,
    input  logic                   pipe_csr_en,
    input  logic [11:0]            pipe_csr_addr,
    input  logic [`DATA_WIDTH-1:0] pipe_csr_wdata,
    input  logic [2:0]             pipe_funct3,
    output logic [`DATA_WIDTH-1:0] pipe_csr_rdata,
    output logic                   CSR_en,
    output logic [11:0]            CSR_Addr,
    output logic [`DATA_WIDTH-1:0] CSR_W_Data,
    output logic [2:0]             Funct3,
    input  logic [`DATA_WIDTH-1:0] CSR_R_Data,
    output logic                   stall,
    output logic                   redirect_valid,
    output logic [`DATA_WIDTH-1:0] redirect_pc
);

    localparam int DW = `DATA_WIDTH;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_MEPC   = 3'd1;
    localparam logic [2:0] S_W_MCAUSE = 3'd2;
    localparam logic [2:0] S_R_MTVEC  = 3'd3;
    localparam logic [2:0] S_R_MEPC   = 3'd4;

    localparam logic [2:0] F3_CSRRW = 3'b001;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] cause_q, cause_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        cause_d        = cause_q;
        req_ack        = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        CSR_en         = 1'b0;
        CSR_Addr       = pipe_csr_addr;
        CSR_W_Data     = '0;
        Funct3         = 3'b000;

        case (state_q)
            S_IDLE: begin
                stall      = 1'b0;
                CSR_en     = pipe_csr_en;
                CSR_W_Data = pipe_csr_wdata;
                Funct3     = pipe_funct3;
                // rst_n gating keeps req_ack low while reset is held, since IDLE is forced then.
                if (rst_n && exc_valid) begin
                    req_ack = 1'b1;
                    CSR_en  = 1'b0;
                    pc_d    = exc_pc;
                    cause_d = {exc_is_irq, {(DW-6){1'b0}}, exc_code};
                    state_d = S_W_MEPC;
                end else if (rst_n && mret_valid) begin
                    req_ack = 1'b1;
                    CSR_en  = 1'b0;
                    state_d = S_R_MEPC;
                end
            end
            S_W_MEPC: begin
                CSR_en     = 1'b1;
                CSR_Addr   = MEPC_ADDR;
                CSR_W_Data = pc_q;
                Funct3     = F3_CSRRW;
                state_d    = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                CSR_en     = 1'b1;
                CSR_Addr   = MCAUSE_ADDR;
                CSR_W_Data = cause_q;
                Funct3     = F3_CSRRW;
                state_d    = S_R_MTVEC;
            end
            S_R_MTVEC: begin
                CSR_Addr       = MTVEC_ADDR;
                redirect_valid = 1'b1;
                state_d        = S_IDLE;
            end
            S_R_MEPC: begin
                CSR_Addr       = MEPC_ADDR;
                redirect_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pipe_csr_rdata = CSR_R_Data;
    // Targets are word aligned; low bits of mtvec (mode) and mepc are dropped.
    assign redirect_pc    = redirect_valid ? {CSR_R_Data[DW-1:2], 2'b00} : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small behavioural CSR file on the write port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid, exc_is_irq, mret_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        req_ack;
    logic        pipe_csr_en;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic [2:0]  pipe_funct3;
    logic [31:0] pipe_csr_rdata;
    logic        CSR_en;
    logic [11:0] CSR_Addr;
    logic [31:0] CSR_W_Data;
    logic [2:0]  Funct3;
    logic [31:0] CSR_R_Data;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .exc_valid(exc_valid), .exc_is_irq(exc_is_irq), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_valid(mret_valid), .req_ack(req_ack),
        .pipe_csr_en(pipe_csr_en), .pipe_csr_addr(pipe_csr_addr),
        .pipe_csr_wdata(pipe_csr_wdata), .pipe_funct3(pipe_funct3),
        .pipe_csr_rdata(pipe_csr_rdata),
        .CSR_en(CSR_en), .CSR_Addr(CSR_Addr), .CSR_W_Data(CSR_W_Data), .Funct3(Funct3),
        .CSR_R_Data(CSR_R_Data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Behavioural CSR file
    logic [31:0] m_mstatus = 32'h0;
    logic [31:0] m_mepc    = 32'h0;
    logic [31:0] m_mcause  = 32'h0;
    logic [31:0] m_mtvec   = 32'h0;

    function automatic logic [31:0] upd(input logic [31:0] old, input logic [2:0] f3,
                                        input logic [31:0] w);
        case (f3)
            3'b001:  return w;
            3'b010:  return old | w;
            3'b011:  return old & ~w;
            default: return old;
        endcase
    endfunction

    always @(posedge clk) begin
        if (CSR_en) begin
            case (CSR_Addr)
                12'h300: m_mstatus <= upd(m_mstatus, Funct3, CSR_W_Data);
                12'h341: m_mepc    <= upd(m_mepc, Funct3, CSR_W_Data);
                12'h342: m_mcause  <= upd(m_mcause, Funct3, CSR_W_Data);
                12'h305: m_mtvec   <= upd(m_mtvec, Funct3, CSR_W_Data);
                default: ;
            endcase
        end
    end

    always_comb begin
        CSR_R_Data = 32'h0;
        case (CSR_Addr)
            12'h300: CSR_R_Data = m_mstatus;
            12'h341: CSR_R_Data = m_mepc;
            12'h342: CSR_R_Data = m_mcause;
            12'h305: CSR_R_Data = m_mtvec;
            default: CSR_R_Data = 32'h0;
        endcase
    end

    int n_redirect = 0;
    always @(negedge clk) if (redirect_valid) n_redirect++;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid      = 1'b0;
        exc_is_irq     = 1'b0;
        exc_code       = 5'd0;
        exc_pc         = 32'h0;
        mret_valid     = 1'b0;
        pipe_csr_en    = 1'b0;
        pipe_csr_addr  = 12'h0;
        pipe_csr_wdata = 32'h0;
        pipe_funct3    = 3'b000;
    endtask

    task automatic pipe_op(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] w);
        pipe_csr_en    = 1'b1;
        pipe_csr_addr  = a;
        pipe_funct3    = f3;
        pipe_csr_wdata = w;
    endtask

    int base_redirect;

    initial begin
        // Reset with every request asserted
        clear_inputs();
        rst_n = 1'b0;
        exc_valid = 1'b1;
        mret_valid = 1'b1;
        pipe_op(12'h340, 3'b001, 32'h5);
        #2;
        $display("step reset_hold");
        chk("rst_req_ack", 32'(req_ack), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_csr_en_pass", 32'(CSR_en), 32'h1);
        chk("rst_csr_addr_pass", 32'(CSR_Addr), 32'h340);
        tick();
        clear_inputs();
        tick();
        rst_n = 1'b1;

        // Preload mtvec through the pass-through port
        tick();
        pipe_op(12'h305, 3'b001, 32'h0000_0200);
        tick();
        clear_inputs();

        // Pipe CSRRS mstatus pass-through
        pipe_op(12'h300, 3'b010, 32'h8);
        #1;
        $display("step pipe_csrrs");
        chk("pass_en", 32'(CSR_en), 32'h1);
        chk("pass_addr", 32'(CSR_Addr), 32'h300);
        chk("pass_wdata", CSR_W_Data, 32'h8);
        chk("pass_funct3", 32'(Funct3), 32'h2);
        chk("pass_rdata_before", pipe_csr_rdata, 32'h0);
        chk("pass_ack", 32'(req_ack), 32'h0);
        tick();
        clear_inputs();
        pipe_csr_addr = 12'h300;
        #1;
        chk("pass_rdata_after", pipe_csr_rdata, 32'h8);
        pipe_op(12'h300, 3'b011, 32'h8);
        tick();
        clear_inputs();
        pipe_csr_addr = 12'h300;
        #1;
        chk("mstatus_cleared", pipe_csr_rdata, 32'h0);

        // Basic exception
        tick();
        exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h0000_0104;
        pipe_op(12'h300, 3'b001, 32'h1);
        #1;
        $display("step exception_basic");
        chk("exc_ack", 32'(req_ack), 32'h1);
        chk("exc_accept_csr_en", 32'(CSR_en), 32'h0);
        chk("exc_accept_stall", 32'(stall), 32'h0);
        tick();
        clear_inputs();
        #1;
        chk("wmepc_stall", 32'(stall), 32'h1);
        chk("wmepc_en", 32'(CSR_en), 32'h1);
        chk("wmepc_addr", 32'(CSR_Addr), 32'h341);
        chk("wmepc_data", CSR_W_Data, 32'h104);
        chk("wmepc_f3", 32'(Funct3), 32'h1);
        chk("wmepc_redirect", 32'(redirect_valid), 32'h0);
        tick(); #1;
        chk("wmcause_en", 32'(CSR_en), 32'h1);
        chk("wmcause_addr", 32'(CSR_Addr), 32'h342);
        chk("wmcause_data", CSR_W_Data, 32'h2);
        chk("wmcause_stall", 32'(stall), 32'h1);
        tick(); #1;
        chk("rmtvec_redirect", 32'(redirect_valid), 32'h1);
        chk("rmtvec_pc", redirect_pc, 32'h200);
        chk("rmtvec_stall", 32'(stall), 32'h1);
        chk("rmtvec_en", 32'(CSR_en), 32'h0);
        chk("rmtvec_addr", 32'(CSR_Addr), 32'h305);
        chk("rmtvec_wdata", CSR_W_Data, 32'h0);
        chk("rmtvec_f3", 32'(Funct3), 32'h0);
        tick(); #1;
        chk("post_exc_stall", 32'(stall), 32'h0);
        chk("post_exc_redirect", 32'(redirect_valid), 32'h0);
        chk("post_exc_redirect_pc", redirect_pc, 32'h0);
        chk("mepc_written", m_mepc, 32'h104);
        chk("mcause_written", m_mcause, 32'h2);
        chk("mstatus_untouched", m_mstatus, 32'h0);

        // MRET with misaligned mepc, then back-to-back interrupt
        pipe_op(12'h341, 3'b001, 32'h0000_0107);
        tick();
        clear_inputs();
        mret_valid = 1'b1;
        #1;
        $display("step mret");
        chk("mret_ack", 32'(req_ack), 32'h1);
        chk("mret_accept_stall", 32'(stall), 32'h0);
        tick();
        clear_inputs();
        #1;
        chk("rmepc_redirect", 32'(redirect_valid), 32'h1);
        chk("rmepc_pc", redirect_pc, 32'h104);
        chk("rmepc_addr", 32'(CSR_Addr), 32'h341);
        chk("rmepc_en", 32'(CSR_en), 32'h0);
        tick();
        exc_valid = 1'b1; exc_is_irq = 1'b1; exc_code = 5'd11; exc_pc = 32'h0000_0300;
        #1;
        $display("step back_to_back_irq");
        chk("b2b_ack", 32'(req_ack), 32'h1);
        tick();
        clear_inputs();
        #1;
        chk("irq_mepc_data", CSR_W_Data, 32'h300);
        tick(); #1;
        chk("irq_mcause_data", CSR_W_Data, 32'h8000_000B);
        tick(); #1;
        chk("irq_redirect_pc", redirect_pc, 32'h200);
        tick(); #1;
        chk("irq_mcause_reg", m_mcause, 32'h8000_000B);
        chk("irq_redirect_off", 32'(redirect_valid), 32'h0);

        // Exception, MRET and pipe CSRRW all in one IDLE cycle
        base_redirect = n_redirect;
        exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'h0000_0400;
        mret_valid = 1'b1;
        pipe_op(12'h300, 3'b001, 32'h8);
        #1;
        $display("step simultaneous");
        chk("sim_ack", 32'(req_ack), 32'h1);
        chk("sim_csr_en", 32'(CSR_en), 32'h0);
        tick();
        exc_valid = 1'b0; mret_valid = 1'b0;
        #1;
        chk("sim_ignore_ack", 32'(req_ack), 32'h0);
        chk("sim_ignore_addr", 32'(CSR_Addr), 32'h341);
        chk("sim_ignore_data", CSR_W_Data, 32'h400);
        tick();
        clear_inputs();
        #1;
        chk("sim_mcause_data", CSR_W_Data, 32'h3);
        tick(); #1;
        chk("sim_redirect", 32'(redirect_valid), 32'h1);
        tick(); tick(); tick(); #1;
        chk("sim_one_redirect", 32'(n_redirect - base_redirect), 32'h1);
        chk("sim_mstatus", m_mstatus, 32'h0);
        chk("sim_mepc", m_mepc, 32'h400);

        // Reset during W_MCAUSE aborts the sequence
        base_redirect = n_redirect;
        exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h0000_0500;
        #1;
        $display("step reset_abort");
        chk("abort_ack", 32'(req_ack), 32'h1);
        tick();
        clear_inputs();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'h0);
        chk("abort_csr_en", 32'(CSR_en), 32'h0);
        chk("abort_redirect", 32'(redirect_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick(); #1;
        chk("abort_mcause_kept", m_mcause, 32'h3);
        chk("abort_mepc", m_mepc, 32'h500);
        chk("abort_no_redirect", 32'(n_redirect - base_redirect), 32'h0);
        chk("abort_idle", 32'(stall), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
